// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller for a fully associative L0 cache: owns the tag/valid
// arrays, does the hit compare, drives LRU updates and sequences line refills.
module cache_refill_ctrl #(
  parameter int LOG2_NUM_BLKS = 3,
  parameter int LOG2_WORDS    = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     cpu_req_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  output logic                     cpu_gnt_o,
  output logic                     cpu_rvalid_o,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     lru_en_o,
  output logic [LOG2_NUM_BLKS-1:0] lru_line_o,
  input  logic [LOG2_NUM_BLKS-1:0] lru_rplc_idx_i,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     data_we_o,
  output logic [LOG2_NUM_BLKS-1:0] data_wline_o,
  output logic [LOG2_WORDS-1:0]    data_wword_o,
  output logic [DATA_W-1:0]        data_wdata_o,
  output logic [LOG2_NUM_BLKS-1:0] data_rline_o,
  output logic [LOG2_WORDS-1:0]    data_rword_o,
  input  logic [DATA_W-1:0]        data_rdata_i
);

  localparam int NUM_LINES = 2**LOG2_NUM_BLKS;
  localparam int TAG_W     = ADDR_W - LOG2_WORDS - 2;

  typedef enum logic [2:0] {IDLE, HIT_RESP, REFILL_REQ, REFILL_DATA, MISS_RESP} state_t;

  state_t                   state_q, state_d;
  logic [NUM_LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]         tag_q [NUM_LINES];
  logic [TAG_W-1:0]         req_tag_q, req_tag_d;
  logic [LOG2_WORDS-1:0]    off_q, off_d;
  logic [LOG2_WORDS-1:0]    beat_q, beat_d;
  logic [LOG2_NUM_BLKS-1:0] victim_q, victim_d;
  logic [DATA_W-1:0]        resp_q, resp_d;
  logic                     tag_we;

  logic [TAG_W-1:0]         cpu_tag;
  logic [LOG2_WORDS-1:0]    cpu_off;
  logic                     hit;
  logic [LOG2_NUM_BLKS-1:0] hit_line;
  logic                     inv_found;
  logic [LOG2_NUM_BLKS-1:0] inv_line;
  logic                     unused_byte_bits;

  assign cpu_tag          = cpu_addr_i[ADDR_W-1:LOG2_WORDS+2];
  assign cpu_off          = cpu_addr_i[LOG2_WORDS+1:2];
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  // Tags are unique, so at most one line matches.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == cpu_tag)) begin
        hit      = 1'b1;
        hit_line = LOG2_NUM_BLKS'(i);
      end
    end
  end

  // Descending scan so the lowest-index invalid line wins.
  always_comb begin
    inv_found = 1'b0;
    inv_line  = '0;
    for (int i = NUM_LINES-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_line  = LOG2_NUM_BLKS'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    req_tag_d    = req_tag_q;
    off_d        = off_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    resp_d       = resp_q;
    tag_we       = 1'b0;
    cpu_gnt_o    = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o  = '0;
    lru_en_o     = 1'b0;
    lru_line_o   = '0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    data_we_o    = 1'b0;
    data_wline_o = '0;
    data_wword_o = '0;
    data_wdata_o = '0;
    data_rline_o = '0;
    data_rword_o = '0;
    case (state_q)
      IDLE: begin
        cpu_gnt_o = !flush_i;
        if (flush_i) begin
          valid_d = '0;
        end else if (cpu_req_i) begin
          if (hit) begin
            lru_en_o     = 1'b1;
            lru_line_o   = hit_line;
            data_rline_o = hit_line;
            data_rword_o = cpu_off;
            state_d      = HIT_RESP;
          end else begin
            req_tag_d         = cpu_tag;
            off_d             = cpu_off;
            victim_d          = inv_found ? inv_line : lru_rplc_idx_i;
            valid_d[victim_d] = 1'b0;
            state_d           = REFILL_REQ;
          end
        end
      end
      HIT_RESP: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = data_rdata_i;
        state_d      = IDLE;
      end
      REFILL_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag_q, {(LOG2_WORDS+2){1'b0}}};
        if (mem_gnt_i) state_d = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (mem_rvalid_i) begin
          data_we_o    = 1'b1;
          data_wline_o = victim_q;
          data_wword_o = beat_q;
          data_wdata_o = mem_rdata_i;
          beat_d       = beat_q + 1'b1;
          if (beat_q == off_q) resp_d = mem_rdata_i;
          if (beat_q == {LOG2_WORDS{1'b1}}) begin
            tag_we            = 1'b1;
            valid_d[victim_q] = 1'b1;
            lru_en_o          = 1'b1;
            lru_line_o        = victim_q;
            state_d           = MISS_RESP;
          end
        end
      end
      MISS_RESP: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o  = resp_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  // Payload registers are only consumed once qualified by state/valid.
  always_ff @(posedge clk) begin
    req_tag_q <= req_tag_d;
    off_q     <= off_d;
    victim_q  <= victim_d;
    resp_q    <= resp_d;
    if (tag_we) tag_q[victim_q] <= req_tag_q;
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural external data array.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_gnt_o, cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  logic        lru_en_o;
  logic [2:0]  lru_line_o, lru_rplc_idx_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        data_we_o;
  logic [2:0]  data_wline_o, data_rline_o;
  logic [1:0]  data_wword_o, data_rword_o;
  logic [31:0] data_wdata_o, data_rdata_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] darr [8][4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_we_o) darr[data_wline_o][data_wword_o] <= data_wdata_o;
    data_rdata_i <= darr[data_rline_o][data_rword_o];
  end

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .lru_en_o(lru_en_o), .lru_line_o(lru_line_o), .lru_rplc_idx_i(lru_rplc_idx_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_we_o(data_we_o), .data_wline_o(data_wline_o), .data_wword_o(data_wword_o),
    .data_wdata_o(data_wdata_o), .data_rline_o(data_rline_o), .data_rword_o(data_rword_o),
    .data_rdata_i(data_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [2:0] victim,
                         input logic [31:0] base, input int off, input int gnt_delay,
                         input bit gap);
    cpu_req_i  = 1'b1;
    cpu_addr_i = addr;
    @(negedge clk);
    chk("miss_gnt", cpu_gnt_o, 1);
    chk("miss_no_lru", lru_en_o, 0);
    tick();
    cpu_req_i = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      mem_gnt_i = (i == gnt_delay);
      @(negedge clk);
      chk("mem_req", mem_req_o, 1);
      chk("mem_addr", mem_addr_o, {addr[31:4], 4'h0});
      tick();
    end
    mem_gnt_i = 1'b0;
    for (int w = 0; w < 4; w++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = base + 32'(w);
      @(negedge clk);
      chk("beat_we", data_we_o, 1);
      chk("beat_wline", data_wline_o, victim);
      chk("beat_wword", data_wword_o, w);
      chk("beat_wdata", data_wdata_o, base + 32'(w));
      chk("beat_lru_en", lru_en_o, (w == 3));
      if (w == 3) chk("beat_lru_line", lru_line_o, victim);
      tick();
      if (gap && w == 1) begin
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("gap_no_we", data_we_o, 0);
        tick();
      end
    end
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("miss_rvalid", cpu_rvalid_o, 1);
    chk("miss_rdata", cpu_rdata_o, base + 32'(off));
    chk("miss_resp_gnt", cpu_gnt_o, 0);
    tick();
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [2:0] line,
                        input logic [1:0] word, input logic [31:0] exp);
    cpu_req_i  = 1'b1;
    cpu_addr_i = addr;
    @(negedge clk);
    chk("hit_gnt", cpu_gnt_o, 1);
    chk("hit_lru_en", lru_en_o, 1);
    chk("hit_lru_line", lru_line_o, line);
    chk("hit_rline", data_rline_o, line);
    chk("hit_rword", data_rword_o, word);
    tick();
    cpu_req_i = 1'b0;
    @(negedge clk);
    chk("hit_rvalid", cpu_rvalid_o, 1);
    chk("hit_rdata", cpu_rdata_o, exp);
    chk("hit_resp_gnt", cpu_gnt_o, 0);
    chk("hit_no_mem_req", mem_req_o, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0;
    lru_rplc_idx_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    chk("rst_gnt", cpu_gnt_o, 1);
    chk("rst_rvalid", cpu_rvalid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_lru_en", lru_en_o, 0);
    chk("rst_we", data_we_o, 0);
    tick();
    rst = 1'b0;
    tick();

    do_miss(32'h100, 3'd0, 32'hA0, 0, 0, 1'b0);
    do_hit(32'h10C, 3'd0, 2'd3, 32'hA3);
    do_miss(32'h208, 3'd1, 32'hB0, 2, 2, 1'b1);
    do_hit(32'h208, 3'd1, 2'd2, 32'hB2);

    for (int k = 0; k < 6; k++)
      do_miss(32'h300 + 32'(k) * 32'h100, 3'(2 + k), 32'hC0 + 32'(k) * 32'h10, 0, 0, 1'b0);
    lru_rplc_idx_i = 3'd5;
    do_miss(32'h904, 3'd5, 32'hD0, 1, 0, 1'b0);
    do_hit(32'h904, 3'd5, 2'd1, 32'hD1);
    do_hit(32'h804, 3'd7, 2'd1, 32'hC1 + 32'h50);
    do_miss(32'h600, 3'd5, 32'hE0, 0, 0, 1'b0);

    flush_i = 1'b1; cpu_req_i = 1'b1; cpu_addr_i = 32'h10C;
    @(negedge clk);
    chk("flush_gnt", cpu_gnt_o, 0);
    chk("flush_lru_en", lru_en_o, 0);
    tick();
    flush_i = 1'b0; cpu_req_i = 1'b0;
    lru_rplc_idx_i = 3'd6;
    do_miss(32'h10C, 3'd0, 32'hF0, 3, 0, 1'b0);

    cpu_req_i = 1'b1; cpu_addr_i = 32'h200;
    tick();
    cpu_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h70 + 32'(w);
      @(negedge clk);
      chk("pre_rst_we", data_we_o, 1);
      chk("pre_rst_wline", data_wline_o, 1);
      tick();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h72;
    rst = 1'b1;
    #1;
    chk("arst_we", data_we_o, 0);
    chk("arst_mem_req", mem_req_o, 0);
    chk("arst_rvalid", cpu_rvalid_o, 0);
    chk("arst_lru_en", lru_en_o, 0);
    chk("arst_gnt", cpu_gnt_o, 1);
    mem_rvalid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    cpu_req_i = 1'b1; cpu_addr_i = 32'h10C;
    @(negedge clk);
    chk("post_rst_gnt", cpu_gnt_o, 1);
    chk("post_rst_no_hit", lru_en_o, 0);
    tick();
    cpu_req_i = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", mem_req_o, 1);
    chk("post_rst_mem_addr", mem_addr_o, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
